// File: rtl/dafx_preset_sequencer.sv
// dafx_preset_sequencer
// Holds a table of (address, data) register writes and, on a start pulse, replays
// entries 0..n-1 in order as single-beat AXI4 write transactions. Only one write is
// outstanding at a time. A non-OKAY response or an abort request ends the sequence
// after the current transaction completes.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   cfg_we/idx/addr/data      table write port, accepted only while cfg_ready
//   cfg_ready                 table writable (not busy)
//   start, count, abort       sequence control
//   busy, done                status; done is a one-cycle completion pulse
//   error, aborted, err_idx   sticky result of the last sequence
//   aw*/w*/b*                 AXI4 write address, write data and response channels
module dafx_preset_sequencer #(
  parameter int unsigned AXI_ADDR_WIDTH_P = 16,
  parameter int unsigned AXI_DATA_WIDTH_P = 64,
  parameter int unsigned AXI_ID_WIDTH_P   = 4,
  parameter logic [AXI_ID_WIDTH_P-1:0] AXI_ID_P = '0,
  parameter int unsigned DEPTH_P          = 16,
  localparam int unsigned IDX_W  = $clog2(DEPTH_P),
  localparam int unsigned CNT_W  = $clog2(DEPTH_P + 1),
  localparam int unsigned STRB_W = AXI_DATA_WIDTH_P / 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_we,
  input  logic [IDX_W-1:0]            cfg_idx,
  input  logic [AXI_ADDR_WIDTH_P-1:0] cfg_addr,
  input  logic [AXI_DATA_WIDTH_P-1:0] cfg_data,
  output logic                        cfg_ready,
  input  logic                        start,
  input  logic [CNT_W-1:0]            count,
  input  logic                        abort,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic                        aborted,
  output logic [IDX_W-1:0]            err_idx,
  output logic [AXI_ID_WIDTH_P-1:0]   awid,
  output logic [AXI_ADDR_WIDTH_P-1:0] awaddr,
  output logic [7:0]                  awlen,
  output logic [2:0]                  awsize,
  output logic [1:0]                  awburst,
  output logic                        awvalid,
  input  logic                        awready,
  output logic [AXI_DATA_WIDTH_P-1:0] wdata,
  output logic [STRB_W-1:0]           wstrb,
  output logic                        wlast,
  output logic                        wvalid,
  input  logic                        wready,
  input  logic [1:0]                  bresp,
  input  logic                        bvalid,
  output logic                        bready
);

  typedef enum logic [1:0] {StIdle, StSend, StWaitB} state_e;

  state_e                      state_q;
  logic [AXI_ADDR_WIDTH_P-1:0] addr_q [DEPTH_P];
  logic [AXI_DATA_WIDTH_P-1:0] data_q [DEPTH_P];
  logic [IDX_W-1:0]            ptr_q;
  logic [CNT_W-1:0]            n_q;
  logic                        abort_q;
  logic                        awvalid_q, wvalid_q, bready_q, done_q;
  logic                        error_q, aborted_q;
  logic [IDX_W-1:0]            err_idx_q;

  logic [CNT_W-1:0] n_start;
  logic             abort_flag;
  logic             last_entry;

  always_comb begin
    n_start    = (count > CNT_W'(DEPTH_P)) ? CNT_W'(DEPTH_P) : count;
    // An abort arriving in the same cycle as the final response still counts.
    abort_flag = abort_q | abort;
    last_entry = (CNT_W'(ptr_q) == (n_q - CNT_W'(1)));
  end

  assign busy      = (state_q != StIdle);
  assign cfg_ready = ~busy;
  assign done      = done_q;
  assign error     = error_q;
  assign aborted   = aborted_q;
  assign err_idx   = err_idx_q;

  // The table cannot change while busy, so these stay stable under back-pressure.
  assign awid    = AXI_ID_P;
  assign awaddr  = addr_q[ptr_q];
  assign awlen   = 8'd0;
  assign awsize  = 3'($clog2(STRB_W));
  assign awburst = 2'b01;
  assign awvalid = awvalid_q;
  assign wdata   = data_q[ptr_q];
  assign wstrb   = '1;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH_P); i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (cfg_we && cfg_ready) begin
      addr_q[cfg_idx] <= cfg_addr;
      data_q[cfg_idx] <= cfg_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      n_q       <= '0;
      abort_q   <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      aborted_q <= 1'b0;
      err_idx_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q != StIdle && abort) abort_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            error_q   <= 1'b0;
            aborted_q <= 1'b0;
            err_idx_q <= '0;
            ptr_q     <= '0;
            abort_q   <= 1'b0;
            n_q       <= n_start;
            if (n_start == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q   <= StSend;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end
          end
        end
        StSend: begin
          // Each channel drops independently after its own handshake.
          if (awready) awvalid_q <= 1'b0;
          if (wready)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
            state_q  <= StWaitB;
            bready_q <= 1'b1;
          end
        end
        StWaitB: begin
          if (bvalid) begin
            bready_q <= 1'b0;
            if (bresp != 2'b00) begin
              error_q   <= 1'b1;
              err_idx_q <= ptr_q;
              aborted_q <= abort_flag;
              done_q    <= 1'b1;
              state_q   <= StIdle;
            end else if (last_entry || abort_flag) begin
              aborted_q <= abort_flag;
              done_q    <= 1'b1;
              state_q   <= StIdle;
            end else begin
              ptr_q     <= ptr_q + 1'b1;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= StSend;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/dafx_preset_sequencer.md
# dafx_preset_sequencer

Configuration sequencer for the dafx register slave: holds a small table of (address, data) register writes and, on command, replays them in order as single-beat AXI4 write transactions into the register bank. Lets the processing system, or a future MIDI/patch front-end, switch a complete mixer/oscillator preset with one start pulse instead of many CPU writes. Sits between the preset source and the write channels of the register slave's AXI4 port, ahead of any interconnect arbitration.

## Interface
- AXI_ADDR_WIDTH_P, 16, AXI address width; matches dafx_address_pkg addresses.
- AXI_DATA_WIDTH_P, 64, AXI data width.
- AXI_ID_P, 0, constant driven on awid.
- DEPTH_P, 16, table entries; power of two, ≥2.
- IDX_W (localparam), $clog2(DEPTH_P); CNT_W (localparam), $clog2(DEPTH_P+1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- cfg_we  in  1  table write strobe.
- cfg_idx  in  IDX_W  table entry index.
- cfg_addr  in  AXI_ADDR_WIDTH_P  register address stored in the entry.
- cfg_data  in  AXI_DATA_WIDTH_P  register data stored in the entry.
- cfg_ready  out  1  table writable (= !busy).
- start  in  1  start-sequence pulse.
- count  in  CNT_W  number of entries to replay from index 0.
- abort  in  1  stop after the outstanding transaction.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky: last sequence ended on a non-OKAY bresp.
- aborted  out  1  sticky: last sequence ended by abort.
- err_idx  out  IDX_W  entry index that returned the error.
- awid  out  ID width  = AXI_ID_P. awaddr  out  AXI_ADDR_WIDTH_P. awlen  out  8, constant 0. awsize  out  3, constant $clog2(AXI_DATA_WIDTH_P/8). awburst  out  2, constant INCR. awvalid  out  1. awready  in  1.
- wdata  out  AXI_DATA_WIDTH_P. wstrb  out  AXI_DATA_WIDTH_P/8, all ones. wlast  out  1, constant 1. wvalid  out  1. wready  in  1.
- bresp  in  2. bvalid  in  1. bready  out  1.

## Operation
- Table: DEPTH_P × (addr, data) flops, reset to 0. Written on cfg_we && cfg_ready. cfg_we while busy is ignored.
- FSM states: IDLE, SEND, WAIT_B.
- IDLE: busy=0. On start, latch n = min(count, DEPTH_P) and clear error, aborted, err_idx, ptr.
  - n==0: assert done next cycle, no AXI traffic, remain in IDLE.
  - n>0: go to SEND with awvalid=wvalid=1, awaddr/wdata taken from entry 0.
- SEND: awvalid and wvalid are independent; each drops the cycle after its own handshake and must never drop before it. awaddr and wdata are stable while their valid is high. Both accepted (same or different cycles) → WAIT_B with bready=1.
- WAIT_B: on bvalid:
  - bresp != 0 → error=1, err_idx=ptr, done, go to IDLE.
  - else if ptr==n-1 or the abort flag is set → done (aborted=1 if the abort flag is set), go to IDLE.
  - else ptr+1 → SEND.
- abort: sampled in any non-IDLE state and latched into an internal flag. The current transaction always completes; no valid is withdrawn. abort in IDLE has no effect. If abort and error occur together, error=1 and aborted=1.
- start while busy is ignored.
- Only one transaction is outstanding at a time. No read channel.

## Timing
- Reset values: awvalid=wvalid=bready=0, busy=0, done=0, error=0, aborted=0, err_idx=0, state IDLE. Reset asserted mid-transaction drops all valids immediately (asynchronously); the slave side is reset by the same domain.
- start in cycle t → awvalid/wvalid high in cycle t+1; busy high from t+1.
- Per entry with a zero-wait slave: SEND 1 cycle, WAIT_B ≥1 cycle. Minimum 2 cycles per entry; n entries take ≥2n cycles.
- done pulses in the cycle after the final bvalid handshake, with busy=0 in that same cycle. A start in the done cycle is accepted.
- bready is high only in WAIT_B.
- error, aborted and err_idx update together with done and hold until the next accepted start.

## Test plan
- Load entries 0–2 = (MIXER_OUTPUT_GAIN_ADDR, 3), (OSC0_FREQUENCY_ADDR, 440<<Q), (OSC0_DUTY_CYCLE_ADDR, 250); start with count=3 against a dafx_axi_slave → exactly three writes in order, done after the 3rd bvalid, and cr_* outputs read back those values.
- Back-pressure: awready delayed 3 cycles and wready delayed 1 cycle → valids held, addr/data stable, no duplicate beats, all entries written once.
- Error: entry 1 addr=0xFFF0 (unmapped, SLVERR) with count=4 → stops after entry 1, error=1, err_idx=1, entries 2–3 not issued.
- Abort asserted during entry 2's WAIT_B with count=8 → entry 2 completes, done, aborted=1, only 3 writes seen.
- count=0 → done in cycle t+1, zero AXI activity. count=DEPTH_P+5 → clamped to DEPTH_P writes. cfg_we while busy → table unchanged.
- Reset asserted while awvalid=1 → awvalid/wvalid/busy drop immediately; after release, start with count=1 issues a clean single write.
